// File: rtl/hs4_req_source_if.sv
// Push port (valid/ready) and four-phase req/ack port of the request source.
interface hs4_req_source_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              req;
  logic [DATA_W-1:0] req_data;
  logic              ack;

  // master: the request source itself; slave: producer plus acknowledger side
  modport master (
    input  in_valid,
    input  in_data,
    input  ack,
    output in_ready,
    output req,
    output req_data
  );

  modport slave (
    output in_valid,
    output in_data,
    output ack,
    input  in_ready,
    input  req,
    input  req_data
  );
endinterface

// File: rtl/hs4_req_source.sv
// Buffers pushed words in a FIFO and offers each on a four-phase req/ack; req rises one cycle after a push into an idle, empty source; in_ready is low while full.
// HS_ACK_SYNC_EN: when defined, ack passes a two-flop synchronizer (each ack edge seen 2 cycles later).

module hs4_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_push_dat,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wptr;
  logic [AW:0]  r_rptr;
  logic         w_wr;
  logic         w_rd;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_wr    = i_push && !o_full;
  assign w_rd    = i_pop && !o_empty;
  assign o_head  = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + {{AW{1'b0}}, 1'b1};
      if (w_rd) r_rptr <= r_rptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wptr[AW-1:0]] <= i_push_dat;
  end
endmodule

module hs4_req_source #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                clk,
  input  logic                rst_n,
  hs4_req_source_if.master    bus,
  input  logic                i_err_clr,
  output logic                o_busy,
  output logic                o_timeout_err,
  output logic [7:0]          o_xfer_cnt
);
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REQ_HI = 2'd1,
    S_REQ_LO = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_req;
  logic [DATA_W-1:0]   r_req_data;
  logic [7:0]          r_tcnt;
  logic [7:0]          r_xfer_cnt;
  logic                r_timeout_err;

  logic                w_ackq;
  logic                w_push;
  logic                w_pop;
  logic                w_load;
  logic                w_xfer_inc;
  logic                w_err_set;
  logic                w_full;
  logic                w_empty;
  logic [DATA_W-1:0]  w_head;
  logic [8:0]          w_tcnt_inc;
  logic                w_tout;

`ifdef HS_ACK_SYNC_EN
  logic r_ack_s1;
  logic r_ack_s2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack_s1 <= 1'b0;
      r_ack_s2 <= 1'b0;
    end else begin
      r_ack_s1 <= bus.ack;
      r_ack_s2 <= r_ack_s1;
    end
  end

  assign w_ackq = r_ack_s2;
`else
  assign w_ackq = bus.ack;
`endif

  assign w_push = bus.in_valid && !w_full;

  hs4_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_push_dat (bus.in_data),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Phase times out once this cycle would make TIMEOUT cycles spent in it.
  assign w_tcnt_inc = {1'b0, r_tcnt} + 9'd1;
  assign w_tout     = (w_tcnt_inc >= 9'(TIMEOUT));

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_load      = 1'b0;
    w_xfer_inc  = 1'b0;
    w_err_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = S_REQ_HI;
          w_load      = 1'b1;
        end
      end
      S_REQ_HI: begin
        if (w_ackq) begin
          w_pop       = 1'b1;
          w_xfer_inc  = 1'b1;
          w_state_nxt = S_REQ_LO;
        end else if (w_tout) begin
          w_pop       = 1'b1;
          w_err_set   = 1'b1;
          w_state_nxt = S_REQ_LO;
        end
      end
      S_REQ_LO: begin
        if (!w_ackq) begin
          if (!w_empty) begin
            w_state_nxt = S_REQ_HI;
            w_load      = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else if (w_tout) begin
          w_err_set   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_req_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == S_REQ_HI);
      if (w_load) r_req_data <= w_head;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
    end else if (w_state_nxt != r_state) begin
      r_tcnt <= '0;
    end else if ((r_state != S_IDLE) && (w_tcnt_inc <= 9'(TIMEOUT))) begin
      r_tcnt <= w_tcnt_inc[7:0];
    end
  end

  // A timeout in the same cycle as err_clr leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
      r_xfer_cnt    <= '0;
    end else begin
      if (w_err_set)      r_timeout_err <= 1'b1;
      else if (i_err_clr) r_timeout_err <= 1'b0;
      if (w_xfer_inc)     r_xfer_cnt    <= r_xfer_cnt + 8'd1;
    end
  end

  assign bus.in_ready  = !w_full;
  assign bus.req       = r_req;
  assign bus.req_data  = r_req_data;
  assign o_busy        = (r_state != S_IDLE) || !w_empty;
  assign o_timeout_err = r_timeout_err;
  assign o_xfer_cnt    = r_xfer_cnt;
endmodule

// File: tb/tb_hs4_req_source.sv
// Randomized and directed bench for hs4_req_source against a queue-based word/occupancy model.
module tb_hs4_req_source;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;
  localparam int TOUT   = 15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       err_clr = 1'b0;
  logic       busy;
  logic       terr;
  logic [7:0] xcnt;

  hs4_req_source_if #(.DATA_W(DATA_W)) bus();

  hs4_req_source #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (TOUT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .i_err_clr     (err_clr),
    .o_busy        (busy),
    .o_timeout_err (terr),
    .o_xfer_cnt    (xcnt)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_q[$];
  int         rise_t[$];
  int         cyc = 0;
  int         n_push = 0;
  int         n_pop = 0;
  int         n_rise = 0;
  bit         sb_en = 1'b0;
  logic       prev_req = 1'b0;
  logic [7:0] held = '0;
  logic [7:0] req_hist = '0;
  int         ack_mode = 1;   // 0: registered responder, 1: stuck at 0, 2: stuck at 1
  int         ack_dly = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Acknowledger: ack follows req one negedge-sample later plus ack_dly extra cycles.
  always @(negedge clk) begin
    req_hist = {req_hist[6:0], bus.req};
    case (ack_mode)
      0:       bus.ack = req_hist[ack_dly+1];
      1:       bus.ack = 1'b0;
      default: bus.ack = 1'b1;
    endcase
  end

  // Scoreboard: each req rise must offer the oldest accepted word; every fall retires it.
  always @(negedge clk) begin
    logic [7:0] tmp;
    if (sb_en) begin
      if (bus.req && !prev_req) begin
        rise_t.push_back(cyc);
        n_rise++;
        if (exp_q.size() == 0) chk("rise_has_word", 0, 1);
        else                   chk("req_data", bus.req_data, exp_q[0]);
        held = bus.req_data;
      end else if (bus.req && prev_req) begin
        chk("req_data_stable", bus.req_data, held);
      end
      if (!bus.req && prev_req) begin
        if (exp_q.size() > 0) tmp = exp_q.pop_front();
        n_pop++;
      end
    end
    prev_req = bus.req;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    sb_en = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    err_clr = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    rise_t.delete();
    n_push = 0;
    n_pop = 0;
    n_rise = 0;
    sb_en = 1'b1;
  endtask

  task automatic push(input logic [7:0] d);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    chk("in_ready", bus.in_ready, (n_push - n_pop) < DEPTH);
    if (bus.in_ready) begin
      exp_q.push_back(d);
      n_push++;
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while ((busy || bus.req) && n < limit) begin
      step();
      n++;
    end
    chk(tag, busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int n;
    int it;
    logic [7:0] d;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    do_reset();
    chk("rst_req", bus.req, 0);
    chk("rst_req_data", bus.req_data, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_terr", terr, 0);
    chk("rst_xcnt", xcnt, 0);

    // Single word, req one cycle after the push
    ack_mode = 0; ack_dly = 0;
    step();
    push(8'hA5);
    chk("t1_req_early", bus.req, 0);
    step();
    chk("t1_req_rise", bus.req, 1);
    chk("t1_req_data", bus.req_data, 8'hA5);
    wait_idle("t1_idle", 50);
    chk("t1_xcnt", xcnt, 1);
    chk("t1_q_empty", exp_q.size(), 0);

    // Back-to-back stream: one rise every 4 cycles
    do_reset();
    ack_mode = 0; ack_dly = 0;
    for (int i = 1; i <= 4; i++) push(8'(i));
    wait_idle("t2_idle", 100);
    chk("t2_rises", rise_t.size(), 4);
    for (int k = 0; k + 1 < rise_t.size(); k++) chk("t2_gap", rise_t[k+1] - rise_t[k], 4);
    chk("t2_xcnt", xcnt, 4);

    // ack stuck low: REQ_HI times out, word discarded, then err_clr
    do_reset();
    ack_mode = 1;
    step();
    push(8'h33);
    step();
    chk("t3_req_rise", bus.req, 1);
    n = 0;
    while (bus.req && n < 40) begin n++; step(); end
    chk("t3_hi_cycles", n, TOUT);
    chk("t3_terr", terr, 1);
    chk("t3_xcnt", xcnt, 0);
    wait_idle("t3_idle", 10);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    chk("t3_err_clr", terr, 0);

    // Timeout set and err_clr in the same cycle: set wins
    err_clr = 1'b1;
    push(8'h44);
    step();
    n = 0;
    while (bus.req && n < 40) begin n++; step(); end
    chk("t3b_hi_cycles", n, TOUT);
    chk("t3b_set_wins", terr, 1);
    step();
    chk("t3b_clr_after", terr, 0);
    err_clr = 1'b0;
    wait_idle("t3b_idle", 10);

    // ack stuck high: one transfer, then REQ_LO times out
    do_reset();
    ack_mode = 2;
    step();
    push(8'h5A);
    step();
    chk("t4_req_rise", bus.req, 1);
    step();
    chk("t4_req_fall", bus.req, 0);
    chk("t4_xcnt", xcnt, 1);
    n = 0;
    while (!terr && n < 40) begin step(); n++; end
    chk("t4_lo_cycles", n, TOUT);
    chk("t4_busy", busy, 0);
    chk("t4_xcnt_hold", xcnt, 1);

    // Fill FIFO with ack stuck low; 5th push ignored
    do_reset();
    ack_mode = 1;
    step();
    for (int i = 0; i < 4; i++) push(8'h10 + 8'(i));
    chk("t5_full", bus.in_ready, 0);
    push(8'h14);
    ack_mode = 0; ack_dly = 0;
    wait_idle("t5_idle", 100);
    chk("t5_xcnt", xcnt, 4);
    chk("t5_rises", n_rise, 4);
    chk("t5_terr", terr, 0);

    // Asynchronous reset mid-handshake
    do_reset();
    ack_mode = 1;
    step();
    push(8'h77);
    step();
    chk("t6_req_pre", bus.req, 1);
    sb_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_req_async", bus.req, 0);
    chk("t6_in_ready", bus.in_ready, 1);
    chk("t6_busy", busy, 0);
    do_reset();
    repeat (3) step();
    chk("t6_no_stale_req", bus.req, 0);
    chk("t6_busy_after", busy, 0);

    // 256 random transfers with random responder delay: xfer_cnt wraps to 0
    ack_mode = 0;
    ack_dly = $urandom_range(0, 3);
    repeat (8) step();
    it = 0;
    while (n_push < 256 && it < 6000) begin
      it++;
      if ($urandom_range(0, 1) == 1) begin
        d = 8'($urandom);
        push(d);
      end else begin
        step();
      end
    end
    chk("t7_sent", n_push, 256);
    wait_idle("t7_idle", 200);
    chk("t7_xcnt_wrap", xcnt, 0);
    chk("t7_rises", n_rise, 256);
    chk("t7_terr", terr, 0);
    chk("t7_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/hs4_req_source.md
# hs4_req_source

Four-phase handshake initiator that feeds the downstream req/ack acknowledger stage. It accepts data words on a valid/ready push port, buffers them in a small FIFO, and presents each word on `req_data` under a full four-phase req/ack cycle. It counts completed transfers and flags an acknowledger that stops responding with a sticky timeout error.

## Interface
- `DATA_W`, default 8: width of pushed and presented data words.
- `FIFO_DEPTH`, default 4: FIFO entries; must be a power of 2, at least 2.
- `TIMEOUT`, default 15: maximum wait cycles per handshake phase, 1..255.
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  push request.
- `in_data`  in  DATA_W  push data.
- `in_ready`  out  1  FIFO not full.
- `req`  out  1  handshake request to the acknowledger.
- `req_data`  out  DATA_W  word offered with `req`.
- `ack`  in  1  acknowledge from the acknowledger.
- `err_clr`  in  1  clears `timeout_err`.
- `busy`  out  1  state is not IDLE, or the FIFO is non-empty.
- `timeout_err`  out  1  sticky timeout flag.
- `xfer_cnt`  out  8  count of completed transfers; wraps.

## Operation
- Reset values: `req`=0, `req_data`=0, `in_ready`=1, `busy`=0, `timeout_err`=0, `xfer_cnt`=0. FIFO empty, state IDLE, timeout counter 0.
- Push: a word is written when `in_valid`&&`in_ready`. `in_ready` = !full.
  - A push and a pop in the same cycle are both honoured; occupancy is unchanged.
  - When full, there is no push, even if a pop occurs that cycle.
- `ackq` is the `ack` value the FSM uses (raw, or synchronized; see Configuration).
- State IDLE, `req`=0:
  - Goes to REQ_HI if the FIFO is non-empty.
  - On that transition, `req_data` loads the FIFO head.
- State REQ_HI, `req`=1; `req_data` is held stable:
  - `ackq`=1: pop the FIFO, `xfer_cnt`+1, go to REQ_LO.
  - Otherwise, when the timeout counter reaches TIMEOUT: pop (discard the word), set `timeout_err`, go to REQ_LO. `xfer_cnt` is unchanged.
- State REQ_LO, `req`=0:
  - `ackq`=0 with the FIFO non-empty: go directly to REQ_HI and load `req_data`.
  - `ackq`=0 with the FIFO empty: go to IDLE.
  - Timeout while still in REQ_LO: set `timeout_err`, go to IDLE.
- Timeout counter: cleared on every state change; counts cycles spent in REQ_HI or REQ_LO; saturates at TIMEOUT.
- `timeout_err`:
  - Cleared by `err_clr`.
  - If a set and `err_clr` occur in the same cycle, the set wins.
- `xfer_cnt` wraps from 255 to 0.
- `rst_n` low mid-handshake: `req` drops immediately (asynchronous). The FIFO is flushed and in-flight words are lost.

## Timing
- FSM outputs are registered; `req` changes only on `clk` edges, except at asynchronous reset.
- Pushed word to `req`: the word is pushed at edge N into an empty FIFO in IDLE. `req`=1 after edge N+1.
- Acknowledger with 1-cycle ack response, raw `ack` path:
  - Edge 0: `req` rises.
  - Edge 2: REQ_LO.
  - Edge 4: next REQ_HI.
  - Result: 4 cycles per word in back-to-back streaming.
- `req_data` is stable from `req` rise until after the pop. It changes only on entry to REQ_HI.

## Configuration
- `HS_ACK_SYNC_EN`:
  - Defined: `ack` passes through a two-flop synchronizer, reset to 0, before the FSM (`ackq` = synchronized `ack`). Each ack edge is seen 2 cycles later, giving 8 cycles per word back-to-back. Use this when the acknowledger is on a different clock.
  - Undefined: the FSM samples `ack` directly (`ackq` = `ack`), with no added latency.

## Test plan
- Reset, then push 0xA5 with a 1-cycle-response acknowledger -> `req` rises 1 cycle after the push, `req_data`=0xA5. `xfer_cnt`=1 after the handshake. `busy` returns to 0.
- Push 0x01..0x04 back-to-back -> `in_ready` stays 1. Words appear in order, one `req` rise every 4 cycles. `xfer_cnt`=4.
- Hold `ack`=0 with TIMEOUT=15 and push 0x33 -> `req` is high for 15 cycles then drops. `timeout_err`=1, the word is discarded, `xfer_cnt`=0. Pulse `err_clr` -> `timeout_err`=0.
- Hold `ack`=1 permanently -> the first transfer completes. REQ_LO times out after 15 cycles, `timeout_err`=1, state IDLE.
- Fill the FIFO with `ack` stuck at 0 -> `in_ready`=0 after 4 pushes. A 5th push is ignored. Release `ack` -> exactly 4 words are transferred.
- Assert `rst_n`=0 while `req`=1 -> `req`=0 immediately and the FIFO is empty. After reset release, run 256 transfers -> `xfer_cnt`=0 (wrap).
